// File: rtl/eel_mux_pkg.sv
// Shared definitions for the round-robin / fixed-select output mux.
//   mux_mode_e : arbitration mode encoding (matches the 1-bit mode_i pin)
//   DEF_N      : default data width per channel
//   DEF_CH     : default channel count
package eel_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  localparam int DEF_N  = 32;
  localparam int DEF_CH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter with its own priority pointer.
//   clk_i, rst_ni : clock, async active-low reset (pointer returns to 0)
//   req_i         : per-channel requests
//   advance_i     : a grant from this arbiter was accepted this cycle
//   gnt_oh_o      : one-hot winner (all zero when no request)
//   gnt_idx_o     : encoded winner index (0 when no request)
module rr_arbiter #(
  parameter int CH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CH-1:0]           req_i,
  input  logic                    advance_i,
  output logic [CH-1:0]           gnt_oh_o,
  output logic [$clog2(CH)-1:0]   gnt_idx_o
);

  localparam int SW = $clog2(CH);

  logic [SW-1:0] ptr_q, ptr_d;

  // Scan CH slots starting at the pointer; the first requester wins.
  always_comb begin : search
    int  j;
    logic found;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < CH; k++) begin
      j = int'(ptr_q) + k;
      if (j >= CH) j = j - CH;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = SW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (gnt_idx_o == SW'(CH - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Multi-channel input mux feeding a single registered output stage.
// Mode 0 takes the channel named by sel_i; mode 1 arbitrates round-robin.
//   clk_i, rst_ni   : clock, async active-low reset
//   mode_i          : 0 = fixed select, 1 = round-robin
//   sel_i           : channel used in fixed mode
//   d_i, valid_i    : per-channel data and request
//   ready_o         : per-channel accept (at most one bit set)
//   dout_o          : registered output word
//   dout_valid_o    : output stage holds an unconsumed word
//   dout_ready_i    : downstream accept
//   grant_o         : source channel of the word in dout_o
module rr_arb_mux
  import eel_mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CH = DEF_CH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mode_i,
  input  logic [$clog2(CH)-1:0]   sel_i,
  input  logic [CH-1:0][N-1:0]    d_i,
  input  logic [CH-1:0]           valid_i,
  output logic [CH-1:0]           ready_o,
  output logic [N-1:0]            dout_o,
  output logic                    dout_valid_o,
  input  logic                    dout_ready_i,
  output logic [$clog2(CH)-1:0]   grant_o
);

  localparam int SW = $clog2(CH);

  mux_mode_e     mode;
  logic [CH-1:0] arb_oh, fix_oh, win_oh;
  logic [SW-1:0] arb_idx, win_idx;
  logic [N-1:0]  win_data;
  logic          stage_free, accept, advance;

  logic [N-1:0]  dout_q, dout_d;
  logic [SW-1:0] grant_q, grant_d;
  logic          dout_valid_q, dout_valid_d;

  assign mode = mux_mode_e'(mode_i);

  rr_arbiter #(.CH(CH)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (valid_i),
    .advance_i (advance),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  // An out-of-range sel_i matches no channel, so it never produces a winner.
  always_comb begin
    fix_oh = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel_i == SW'(i)) fix_oh[i] = valid_i[i];
    end
  end

  assign win_oh  = (mode == MODE_RR) ? arb_oh  : fix_oh;
  assign win_idx = (mode == MODE_RR) ? arb_idx : sel_i;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (win_oh[i]) win_data = d_i[i];
    end
  end

  // rst_ni gates ready so nothing is offered while reset is held.
  assign stage_free = !dout_valid_q || dout_ready_i;
  assign ready_o    = (stage_free && rst_ni) ? win_oh : '0;
  assign accept     = |ready_o;
  assign advance    = accept && (mode == MODE_RR);

  always_comb begin
    dout_d       = dout_q;
    grant_d      = grant_q;
    dout_valid_d = dout_valid_q;
    if (accept) begin
      dout_d       = win_data;
      grant_d      = win_idx;
      dout_valid_d = 1'b1;
    end else if (dout_ready_i) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q       <= '0;
      grant_q      <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      grant_q      <= grant_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_o       = dout_q;
  assign grant_o      = grant_q;
  assign dout_valid_o = dout_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  localparam int N  = 32;
  localparam int CH = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 mode_i;
  logic [2:0]           sel_i;
  logic [CH-1:0][N-1:0] d_i;
  logic [CH-1:0]        valid_i;
  logic [CH-1:0]        ready_o;
  logic [N-1:0]         dout_o;
  logic                 dout_valid_o;
  logic                 dout_ready_i;
  logic [2:0]           grant_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rr_arb_mux #(.N(N), .CH(CH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mode_i       (mode_i),
    .sel_i        (sel_i),
    .d_i          (d_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .grant_o      (grant_o)
  );

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       drdy;
    logic [7:0] exp_ready;
    logic       exp_dv;
    logic [2:0] exp_grant;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] word_of(input logic [2:0] ch);
    return 32'hA5A5_0000 | {29'd0, ch};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] v, input logic r);
    mode_i       = m;
    sel_i        = s;
    valid_i      = v;
    dout_ready_i = r;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic dv, input logic [2:0] g);
    check({tag, ".dout_valid"}, {31'd0, dout_valid_o}, {31'd0, dv});
    check({tag, ".grant"}, {29'd0, grant_o}, {29'd0, g});
    check({tag, ".dout"}, dout_o, word_of(g));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    check("rst.dout_valid", {31'd0, dout_valid_o}, 32'd0);
    check("rst.dout", dout_o, 32'd0);
    check("rst.grant", {29'd0, grant_o}, 32'd0);
    check("rst.ready", {24'd0, ready_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < CH; i++) d_i[i] = word_of(3'(i));
    rst_ni = 1'b0;
    drive(1'b1, 3'd0, 8'hFF, 1'b1);

    // {mode, sel, valid, dout_ready, ready, next dout_valid, next grant}
    vecs[0]  = '{1'b0, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3};
    vecs[1]  = '{1'b0, 3'd7, 8'h01, 1'b1, 8'h00, 1'b0, 3'd3};
    vecs[2]  = '{1'b1, 3'd7, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0};
    vecs[3]  = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7};
    vecs[4]  = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0};
    vecs[5]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 3'd0, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2};
    vecs[7]  = '{1'b0, 3'd2, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2};
    vecs[8]  = '{1'b1, 3'd0, 8'h0C, 1'b1, 8'h08, 1'b1, 3'd3};
    vecs[9]  = '{1'b1, 3'd0, 8'h0C, 1'b0, 8'h00, 1'b1, 3'd3};
    vecs[10] = '{1'b1, 3'd0, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2};
    vecs[11] = '{1'b1, 3'd0, 8'h0C, 1'b0, 8'h00, 1'b1, 3'd2};
    vecs[12] = '{1'b0, 3'd5, 8'h20, 1'b0, 8'h00, 1'b1, 3'd2};
    vecs[13] = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5};
    vecs[14] = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5};

    // Reset held with requests present: nothing may be offered.
    #2;
    do_reset();

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].mode, vecs[v].sel, vecs[v].valid, vecs[v].drdy);
      #1;
      check($sformatf("vec%0d.ready", v), {24'd0, ready_o}, {24'd0, vecs[v].exp_ready});
      tick();
      check_out($sformatf("vec%0d", v), vecs[v].exp_dv, vecs[v].exp_grant);
    end

    // Round-robin streaming with all channels requesting.
    drive(1'b1, 3'd0, 8'hFF, 1'b1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("rr%0d.ready", k), {24'd0, ready_o}, 32'd1 << (k % 8));
      tick();
      check_out($sformatf("rr%0d", k), 1'b1, 3'(k % 8));
    end

    // Back-pressure: output full and not consumed for 5 cycles.
    dout_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d.ready", k), {24'd0, ready_o}, 32'd0);
      tick();
      check_out($sformatf("stall%0d", k), 1'b1, 3'd1);
    end
    dout_ready_i = 1'b1;
    #1;
    check("unstall.ready", {24'd0, ready_o}, 32'h04);
    tick();
    check_out("unstall", 1'b1, 3'd2);

    // Asynchronous reset mid-stream, away from the clock edge.
    tick();
    check_out("pre_rst", 1'b1, 3'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst.dout_valid", {31'd0, dout_valid_o}, 32'd0);
    check("arst.dout", dout_o, 32'd0);
    check("arst.grant", {29'd0, grant_o}, 32'd0);
    check("arst.ready", {24'd0, ready_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    #1;
    check("post_rst.ready", {24'd0, ready_o}, 32'h01);
    tick();
    check_out("post_rst0", 1'b1, 3'd0);
    tick();
    check_out("post_rst1", 1'b1, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
